i2c_scanner_axil_regbank: RTL and testbench
===========================================

// Module: i2c_scanner_axil_regbank
// PURPOSE
// - Parametrised AXI4-Lite slave register bank for the next-generation I2C scanner peripheral.
// - Replaces the fixed 4-register slave.
// - Adds configurable register count, read-only status registers, byte strobes, per-register
//   write pulses and out-of-range detection.
// - Sits between the AXI interconnect and the I2C scan engine; the engine consumes the
//   control registers and drives the status registers.
// PARAMETERS
// - C_S_AXI_DATA_WIDTH  32     AXI data width; 32 or 64.
// - C_S_AXI_ADDR_WIDTH  6      AXI byte-address width; must satisfy 2**(ADDR_WIDTH-ADDRLSB) >= NUM_REGS.
// - NUM_REGS            8      Number of registers, 1..64.
// - RO_MASK             'hF0   Bit i set: register i is read-only and mirrors status_i slice i.
// PORTS
// - S_AXI_ACLK     in   1       Clock.
// - S_AXI_ARESETN  in   1       Asynchronous active-low reset.
// - S_AXI_AWADDR   in   AW      Write address.
// - S_AXI_AWPROT   in   3       Ignored.
// - S_AXI_AWVALID  in   1       Write address valid.
// - S_AXI_AWREADY  out  1       Write address ready.
// - S_AXI_WDATA    in   DW      Write data.
// - S_AXI_WSTRB    in   DW/8    Byte strobes.
// - S_AXI_WVALID   in   1       Write data valid.
// - S_AXI_WREADY   out  1       Write data ready.
// - S_AXI_BRESP    out  2       Write response.
// - S_AXI_BVALID   out  1       Write response valid.
// - S_AXI_BREADY   in   1       Write response ready.
// - S_AXI_ARADDR   in   AW      Read address.
// - S_AXI_ARPROT   in   3       Ignored.
// - S_AXI_ARVALID  in   1       Read address valid.
// - S_AXI_ARREADY  out  1       Read address ready.
// - S_AXI_RDATA    out  DW      Read data.
// - S_AXI_RRESP    out  2       Read response.
// - S_AXI_RVALID   out  1       Read data valid.
// - S_AXI_RREADY   in   1       Read data ready.
// - ctrl_o         out  NUM_REGS*DW  Flattened register contents; read-only slots are driven 0.
// - status_i       in   NUM_REGS*DW  Flattened status inputs; only read-only slots are used.
// - wr_pulse_o     out  NUM_REGS     One-cycle pulse on each committed write to a writable register.
// BEHAVIOUR
// - Reset values: all outputs 0, all writable registers 0, AW/W holding buffers empty.
// - Reset takes effect immediately; in-flight transactions are dropped, no response is issued.
// - Register index: idx = addr[AW-1:ADDRLSB], where ADDRLSB = log2(DW/8).
//   Index >= NUM_REGS is out of range.
// - Write channel:
//   - AW and W are accepted independently, each into its own 1-entry buffer.
//   - AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID.
//   - Commit happens in the first cycle both buffers are full (this may be the accept cycle's next
//     edge).
//   - On commit, for each byte b with WSTRB[b]=1: reg[idx][8b+7:8b] <= WDATA byte.
//   - On commit: wr_pulse_o[idx]=1 for one cycle; BVALID=1 the cycle after commit; both buffers
//     cleared.
//   - Write to a read-only register: no update, no pulse, BRESP=OKAY.
//   - Write out of range: no update, no pulse, BRESP per CONFIGURATION.
//   - BVALID holds with stable BRESP until BREADY; it clears on the BVALID&&BREADY edge.
// - Read channel:
//   - ARREADY = !RVALID.
//   - On AR handshake: RDATA/RRESP registered, RVALID=1 next cycle (1-cycle latency).
//   - Read-only index returns the live status_i slice sampled on the AR handshake edge.
//   - RDATA/RRESP are stable while RVALID && !RREADY; RVALID clears on the handshake edge.
// - Simultaneous read and write commit to the same register in one cycle: the read returns the
//   pre-write value.
// - Back-to-back: the bank sustains one write per 2 cycles and one read per 2 cycles.
//   The read and write paths are fully independent.
// - WSTRB=0 commits with no data change but still pulses wr_pulse_o and responds OKAY.
// CONFIGURATION
// - Macro I2CS_AXIL_SLVERR_EN:
//   - Defined: out-of-range read returns RDATA=0, RRESP=SLVERR(2'b10); out-of-range write returns
//     BRESP=SLVERR.
//   - Undefined: out-of-range accesses return RDATA=0 with OKAY and writes are silently dropped.
// TESTING
// - Write 0x1,0x2,0x3,0x4 to addr 0x0,0x4,0x8,0xC, then read them back
//   -> each read returns the written value, RRESP=OKAY, exactly one wr_pulse_o per write.
// - W presented 3 cycles before AW (addr 0x4, data 0xA5A5A5A5)
//   -> WREADY drops after W accept, commit on AW accept, BVALID 1 cycle later, reg1=0xA5A5A5A5.
// - Reg0=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> reg0 reads 0xFF34FF78.
// - status_i slot 4 = 0xDEADBEEF, write 0x0 to addr 0x10
//   -> no pulse, BRESP=OKAY, read of 0x10 returns 0xDEADBEEF.
// - Access addr 0x20 (idx 8) with the macro defined -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0.
//   With the macro undefined -> both responses OKAY.
// - Hold BREADY/RREADY low 5 cycles, then assert ARESETN low mid-response
//   -> BVALID/RVALID go 0 immediately and all registers read 0 after release.

Source files
------------

// File: rtl/i2c_scanner_axil_regbank.sv
// AXI4-Lite register bank for the I2C scanner: writable control regs, read-only status mirrors.
// Optional macro I2CS_AXIL_SLVERR_EN: out-of-range accesses respond SLVERR instead of OKAY.
module i2c_scanner_axil_regbank #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
   parameter int unsigned NUM_REGS           = 8,
   parameter logic [63:0] RO_MASK            = 64'hF0
) (
   input  logic                                     S_AXI_ACLK,
   input  logic                                     S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
   input  logic [2:0]                               S_AXI_AWPROT,
   input  logic                                     S_AXI_AWVALID,
   output logic                                     S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
   input  logic                                     S_AXI_WVALID,
   output logic                                     S_AXI_WREADY,
   output logic [1:0]                               S_AXI_BRESP,
   output logic                                     S_AXI_BVALID,
   input  logic                                     S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
   input  logic [2:0]                               S_AXI_ARPROT,
   input  logic                                     S_AXI_ARVALID,
   output logic                                     S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
   output logic [1:0]                               S_AXI_RRESP,
   output logic                                     S_AXI_RVALID,
   input  logic                                     S_AXI_RREADY,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   ctrl_o,
   input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   status_i,
   output logic [NUM_REGS-1:0]                      wr_pulse_o
);

   localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
   localparam int unsigned AW      = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned SW      = DW / 8;
   localparam int unsigned ADDRLSB = $clog2(SW);
   localparam int unsigned IW      = AW - ADDRLSB;

   localparam logic [1:0] RespOkay = 2'b00;
`ifdef I2CS_AXIL_SLVERR_EN
   localparam logic [1:0] RespOor  = 2'b10;
`else
   localparam logic [1:0] RespOor  = 2'b00;
`endif

   logic          aw_full_q, aw_full_d;
   logic [IW-1:0] aw_idx_q, aw_idx_d;
   logic          w_full_q, w_full_d;
   logic [DW-1:0] w_data_q, w_data_d;
   logic [SW-1:0] w_strb_q, w_strb_d;
   logic          bvalid_q, bvalid_d;
   logic [1:0]    bresp_q, bresp_d;
   logic          rvalid_q, rvalid_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [1:0]    rresp_q, rresp_d;
   logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
   logic [DW-1:0] regs_q [NUM_REGS];
   logic [DW-1:0] regs_d [NUM_REGS];

   logic          aw_hs, w_hs, ar_hs, commit;
   logic [IW-1:0] wr_idx, rd_idx;
   logic [DW-1:0] wr_data, rd_data;
   logic [SW-1:0] wr_strb;
   logic          wr_in_range, rd_in_range;

   assign S_AXI_AWREADY = !aw_full_q && !bvalid_q;
   assign S_AXI_WREADY  = !w_full_q && !bvalid_q;
   assign S_AXI_ARREADY = !rvalid_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign wr_pulse_o    = wr_pulse_q;

   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

   // A beat accepted this cycle counts as buffered, so matched AW/W commit on the accept edge.
   assign commit  = (aw_full_q || aw_hs) && (w_full_q || w_hs);
   assign wr_idx  = aw_full_q ? aw_idx_q : S_AXI_AWADDR[AW-1:ADDRLSB];
   assign wr_data = w_full_q ? w_data_q : S_AXI_WDATA;
   assign wr_strb = w_full_q ? w_strb_q : S_AXI_WSTRB;
   assign rd_idx  = S_AXI_ARADDR[AW-1:ADDRLSB];

   assign wr_in_range = {1'b0, wr_idx} < (IW + 1)'(NUM_REGS);
   assign rd_in_range = {1'b0, rd_idx} < (IW + 1)'(NUM_REGS);

   always_comb begin
      aw_full_d = aw_full_q;
      aw_idx_d  = aw_idx_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_idx_d  = S_AXI_AWADDR[AW-1:ADDRLSB];
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end
      if (commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
      end
   end

   always_comb begin
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
      if (commit) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_in_range ? RespOkay : RespOor;
      end
   end

   always_comb begin
      regs_d     = regs_q;
      wr_pulse_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (commit && !RO_MASK[i] && (wr_idx == IW'(i))) begin
            wr_pulse_d[i] = 1'b1;
            for (int b = 0; b < SW; b++) begin
               if (wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end
   end

   // Read mux sees regs_q, so a read racing a commit to the same register returns the old value.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IW'(i)) rd_data = RO_MASK[i] ? status_i[i*DW +: DW] : regs_q[i];
      end
   end

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_in_range ? rd_data : '0;
         rresp_d  = rd_in_range ? RespOkay : RespOor;
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         aw_full_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_full_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= 2'b00;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= 2'b00;
         wr_pulse_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         aw_full_q  <= aw_full_d;
         aw_idx_q   <= aw_idx_d;
         w_full_q   <= w_full_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         wr_pulse_q <= wr_pulse_d;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
      assign ctrl_o[g*DW +: DW] = RO_MASK[g] ? '0 : regs_q[g];
   end

   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDRLSB-1:0],
                        S_AXI_ARADDR[ADDRLSB-1:0]};

endmodule

// File: tb/tb_i2c_scanner_axil_regbank.sv
// Randomised scoreboard bench for i2c_scanner_axil_regbank; expected B/R responses are queued
// at issue time from a plain array model and checked by a separate monitor process.
module tb_i2c_scanner_axil_regbank;

   localparam int DW = 32;
   localparam int NR = 8;
   localparam logic [7:0] RO = 8'hF0;
`ifdef I2CS_AXIL_SLVERR_EN
   localparam logic [1:0] ERR = 2'b10;
`else
   localparam logic [1:0] ERR = 2'b00;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   logic              clk, rst_n;
   logic [5:0]        awaddr, araddr;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rvalid, rready;
   logic [31:0]       wdata, rdata;
   logic [3:0]        wstrb;
   logic [1:0]        bresp, rresp;
   logic [NR*DW-1:0]  ctrl, status;
   logic [NR-1:0]     wr_pulse;

   logic [1:0]  bq[$];
   rexp_t       rq[$];
   logic [31:0] model [NR];
   int          exp_pulse [NR];
   int          pulse_cnt [NR];
   int          total = 0, bad = 0;
   int          cyc = 0, last_aw = 0, last_w = 0;
   logic        bvalid_prev = 1'b0;
   int          rdy_mode = 0;

   i2c_scanner_axil_regbank dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .ctrl_o(ctrl), .status_i(status), .wr_pulse_o(wr_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic rexp_t exp_read(input int idx);
      rexp_t e;
      e.resp = 2'b00;
      if (idx >= NR) begin
         e.data = '0;
         e.resp = ERR;
      end else if (RO[idx]) e.data = status[idx*32 +: 32];
      else e.data = model[idx];
      return e;
   endfunction

   // Monitor: pops the scoreboard on every B/R handshake and checks commit-to-BVALID latency.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bvalid && bready) begin
            if (bq.size() == 0) check("b_unexpected", 1, 0);
            else check("bresp", bresp, bq.pop_front());
         end
         if (rvalid && rready) begin
            if (rq.size() == 0) check("r_unexpected", 1, 0);
            else begin
               rexp_t e;
               e = rq.pop_front();
               check("rdata", rdata, e.data);
               check("rresp", rresp, e.resp);
            end
         end
         if (bvalid && !bvalid_prev)
            check("b_latency", cyc, ((last_aw > last_w) ? last_aw : last_w) + 1);
         if (awvalid && awready) last_aw = cyc;
         if (wvalid && wready) last_w = cyc;
      end
      for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
      bvalid_prev = bvalid;
   end

   initial begin
      bready = 1'b0;
      rready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: begin
               bready = ($urandom % 3) != 0;
               rready = ($urandom % 3) != 0;
            end
            1: begin
               bready = 1'b0;
               rready = 1'b0;
            end
            default: begin
               bready = 1'b1;
               rready = 1'b1;
            end
         endcase
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (bq.size() != 0 || rq.size() != 0) begin
         check("drain_timeout", bq.size() + rq.size(), 0);
         bq.delete();
         rq.delete();
      end
   endtask

   task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input bit wait_b);
      int idx;
      logic [NR*DW-1:0] exp_ctrl;
      idx = int'(addr[5:2]);
      if (idx < NR && !RO[idx]) begin
         for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
         exp_pulse[idx]++;
      end
      bq.push_back((idx < NR) ? 2'b00 : ERR);
      fork
         begin : aw_ch
            int n;
            n = 0;
            repeat (aw_dly) @(posedge clk);
            #1;
            awaddr  = addr;
            awvalid = 1'b1;
            do begin
               @(negedge clk);
               n++;
            end while (!awready && n < 50);
            if (!awready) check("aw_timeout", 1, 0);
            @(posedge clk);
            #1;
            awvalid = 1'b0;
         end
         begin : w_ch
            int n;
            n = 0;
            repeat (w_dly) @(posedge clk);
            #1;
            wdata  = data;
            wstrb  = strb;
            wvalid = 1'b1;
            do begin
               @(negedge clk);
               n++;
            end while (!wready && n < 50);
            if (!wready) check("w_timeout", 1, 0);
            @(posedge clk);
            #1;
            wvalid = 1'b0;
         end
      join
      if (wait_b) begin
         drain();
         for (int i = 0; i < NR; i++) exp_ctrl[i*32 +: 32] = RO[i] ? 32'h0 : model[i];
         check("ctrl_o", ctrl, exp_ctrl);
      end
   endtask

   task automatic do_read(input logic [5:0] addr, input bit wait_r);
      int n;
      n = 0;
      rq.push_back(exp_read(int'(addr[5:2])));
      araddr  = addr;
      arvalid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!arready && n < 50);
      if (!arready) check("ar_timeout", 1, 0);
      @(posedge clk);
      #1;
      arvalid = 1'b0;
      if (wait_r) drain();
   endtask

   initial begin
      int p4, idx;
      rst_n   = 1'b0;
      awaddr  = '0;
      awvalid = 1'b0;
      wdata   = '0;
      wstrb   = '0;
      wvalid  = 1'b0;
      araddr  = '0;
      arvalid = 1'b0;
      status  = '0;
      for (int i = 0; i < NR; i++) begin
         model[i]     = '0;
         exp_pulse[i] = 0;
         pulse_cnt[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_pulse", wr_pulse, 0);
      check("rst_ctrl", ctrl, 0);
      check("rst_rdata", rdata, 0);
      check("rst_bresp", bresp, 0);
      check("rst_rresp", rresp, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic write then read-back of four registers.
      for (int i = 0; i < 4; i++) do_write(6'(i * 4), 32'(i + 1), 4'hF, $urandom % 3, $urandom % 3, 1);
      for (int i = 0; i < 4; i++) do_read(6'(i * 4), 1);
      for (int i = 0; i < 4; i++) check("one_pulse_per_write", pulse_cnt[i], 1);

      // W leads AW by three cycles.
      fork
         do_write(6'h04, 32'hA5A5A5A5, 4'hF, 3, 0, 1);
         begin
            @(negedge clk);
            @(negedge clk);
            check("wready_after_w", wready, 0);
            check("no_b_before_aw", bvalid, 0);
         end
      join
      do_read(6'h04, 1);

      // Byte strobes.
      do_write(6'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 1);
      do_write(6'h00, 32'h12345678, 4'b0101, 1, 0, 1);
      do_read(6'h00, 1);

      // Read-only slot mirrors status and ignores writes.
      status[4*32 +: 32] = 32'hDEADBEEF;
      p4 = pulse_cnt[4];
      do_write(6'h10, 32'h0, 4'hF, 0, 1, 1);
      check("ro_no_pulse", pulse_cnt[4], p4);
      do_read(6'h10, 1);

      // Out of range index 8.
      do_write(6'h20, 32'h55AA55AA, 4'hF, 0, 0, 1);
      do_read(6'h20, 1);

      // Randomised mix.
      repeat (150) begin
         if ($urandom % 4 == 0)
            for (int i = 4; i < NR; i++) status[i*32 +: 32] = $urandom;
         idx = int'($urandom_range(0, 9));
         if ($urandom % 2 == 0)
            do_write(6'(idx * 4), $urandom, 4'($urandom), $urandom % 4, $urandom % 4, 1);
         else
            do_read(6'(idx * 4 + ($urandom % 4)), 1);
      end

      // Reset while responses are held off.
      rdy_mode = 1;
      status   = '0;
      do_write(6'h08, 32'hCAFE0001, 4'hF, 0, 0, 0);
      do_read(6'h0C, 0);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_mid_bvalid", bvalid, 0);
      check("rst_mid_rvalid", rvalid, 0);
      bq.delete();
      rq.delete();
      for (int i = 0; i < NR; i++) model[i] = '0;
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      rdy_mode = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) do_read(6'(i * 4), 1);

      for (int i = 0; i < NR; i++) check("pulse_total", pulse_cnt[i], exp_pulse[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
